imem_resp: RTL and testbench

IMEM_RESP -- requirements
Module: imem_resp

---
 rtl/imem_pkg.sv | 13 +
 rtl/imem_resp_if.sv | 37 +++
 rtl/imem_array.sv | 26 ++
 rtl/imem_resp.sv | 89 ++++++++
 tb/tb_imem_resp.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory responder.
//   imem_state_t : LOAD (accepting program words) / RUN (serving fetches)
//   NOP          : instruction returned whenever no real word is presented
package imem_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } imem_state_t;

  localparam logic [31:0] NOP = 32'hD503201F;

endpackage

// File: rtl/imem_resp_if.sv
// Bus bundle between the fetch stage / program loader and imem_resp.
//   imem_addr_F, stall_F            : fetch request (byte address, hold)
//   load_valid, load_data, load_last: program word offered by the loader
//   load_ready                      : responder accepts load words
//   instr_F, instr_valid_F, fault_F : fetch response, one cycle after sampling
//   words_loaded                    : words written since reset
// Load handshake: a word transfers on a rising edge where load_valid and
// load_ready are both high; load_data/load_last are only meaningful while
// load_valid is high, and the loader may drop load_valid at any time.
interface imem_resp_if #(
  parameter int N_WORDS = 64,
  parameter int IW      = 32
);
  localparam int AW = $clog2(N_WORDS);

  logic [63:0]   imem_addr_F;
  logic          stall_F;
  logic          load_valid;
  logic [IW-1:0] load_data;
  logic          load_last;
  logic          load_ready;
  logic [IW-1:0] instr_F;
  logic          instr_valid_F;
  logic          fault_F;
  logic [AW:0]   words_loaded;

  modport master (
    output imem_addr_F, stall_F, load_valid, load_data, load_last,
    input  load_ready, instr_F, instr_valid_F, fault_F, words_loaded
  );

  modport slave (
    input  imem_addr_F, stall_F, load_valid, load_data, load_last,
    output load_ready, instr_F, instr_valid_F, fault_F, words_loaded
  );

endinterface

// File: rtl/imem_array.sv
// N_WORDS x IW storage: synchronous write port, registered read port.
//   we/waddr/wdata : write on rising edge when we=1
//   re/raddr/rdata : rdata updates on rising edge when re=1, holds otherwise
// Contents are deliberately not reset; a reload simply overwrites them.
module imem_array #(
  parameter  int N_WORDS = 64,
  parameter  int IW      = 32,
  localparam int AW      = $clog2(N_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);

  logic [IW-1:0] mem [N_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_resp.sv
// Instruction memory responder. After reset it sits in LOAD and accepts
// program words in order; once the last word (load_last, or the top
// location) is written it moves to RUN and answers fetches with one cycle
// of latency. Only reset leaves RUN.
//   clk, reset : single clock, synchronous active-high reset
//   bus        : imem_resp_if slave modport (load + fetch signals)
//   state_dbg  : current FSM state, for observation
module imem_resp
  import imem_pkg::*;
#(
  parameter int N_WORDS = 64,
  parameter int IW      = 32
) (
  input  logic        clk,
  input  logic        reset,
  imem_resp_if.slave  bus,
  output imem_state_t state_dbg
);

  localparam int AW = $clog2(N_WORDS);

  imem_state_t   state;
  logic [AW:0]   words_loaded_q;
  logic          valid_q;
  logic          fault_q;
  logic [IW-1:0] rdata;

  // words_loaded never exceeds N_WORDS and the pointer never wraps, so the
  // write pointer is just its low bits.
  logic [AW-1:0] wptr;
  logic          load_fire;
  logic          sample;
  logic          addr_fault;
  logic [AW-1:0] ridx;

  assign wptr       = words_loaded_q[AW-1:0];
  assign load_fire  = (state == LOAD) && bus.load_valid;
  assign sample     = (state == RUN) && !bus.stall_F;
  assign ridx       = bus.imem_addr_F[AW+1:2];
  assign addr_fault = (|bus.imem_addr_F[1:0]) || (|bus.imem_addr_F[63:AW+2]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= LOAD;
      words_loaded_q <= '0;
      valid_q        <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          valid_q <= 1'b0;
          fault_q <= 1'b0;
          if (bus.load_valid) begin
            words_loaded_q <= words_loaded_q + 1'b1;
            if (bus.load_last || (wptr == AW'(N_WORDS - 1))) state <= RUN;
          end
        end
        RUN: begin
          // While stalled the flags and the array read register all hold.
          if (!bus.stall_F) begin
            valid_q <= 1'b1;
            fault_q <= addr_fault;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  imem_array #(.N_WORDS(N_WORDS), .IW(IW)) u_array (
    .clk   (clk),
    .we    (load_fire),
    .waddr (wptr),
    .wdata (bus.load_data),
    .re    (sample),
    .raddr (ridx),
    .rdata (rdata)
  );

  // rdata is not reset and is meaningless for faulting addresses, so the
  // registered flags decide whether it is exposed.
  assign bus.instr_F       = (valid_q && !fault_q) ? rdata : IW'(NOP);
  assign bus.instr_valid_F = valid_q;
  assign bus.fault_F       = fault_q;
  assign bus.load_ready    = (state == LOAD);
  assign bus.words_loaded  = words_loaded_q;
  assign state_dbg         = state;

endmodule

// File: tb/tb_imem_resp.sv
module tb_imem_resp;
  import imem_pkg::*;

  localparam int N_WORDS = 64;
  localparam int IW      = 32;
  localparam int AW      = $clog2(N_WORDS);

  // clock / reset
  logic        clk = 1'b0;
  logic        reset;
  imem_state_t state_dbg;

  always #5 clk = ~clk;

  imem_resp_if #(.N_WORDS(N_WORDS), .IW(IW)) bus ();

  imem_resp #(.N_WORDS(N_WORDS), .IW(IW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // scoreboard: {fault, instr}
  logic [IW:0]   exp_q[$];
  logic [IW-1:0] model_mem[N_WORDS];
  int            exp_words;
  int            n_checks = 0;
  int            n_fail   = 0;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset(input string tag);
    reset           = 1'b1;
    bus.load_valid  = 1'b0;
    bus.load_last   = 1'b0;
    bus.load_data   = '0;
    bus.stall_F     = 1'b0;
    bus.imem_addr_F = '0;
    tick();
    tick();
    reset     = 1'b0;
    exp_words = 0;
    exp_q.delete();
    n_checks++; if (bus.load_ready !== 1'b1) begin n_fail++; $display("FAIL %s load_ready: got %b want 1", tag, bus.load_ready); end
    n_checks++; if (bus.words_loaded !== '0) begin n_fail++; $display("FAIL %s words_loaded: got %0d want 0", tag, bus.words_loaded); end
    n_checks++; if (bus.instr_valid_F !== 1'b0) begin n_fail++; $display("FAIL %s instr_valid_F: got %b want 0", tag, bus.instr_valid_F); end
    n_checks++; if (bus.instr_F !== NOP) begin n_fail++; $display("FAIL %s instr_F: got %h want %h", tag, bus.instr_F, NOP); end
    n_checks++; if (bus.fault_F !== 1'b0) begin n_fail++; $display("FAIL %s fault_F: got %b want 0", tag, bus.fault_F); end
    n_checks++; if (state_dbg !== LOAD) begin n_fail++; $display("FAIL %s state: got %0d want LOAD", tag, state_dbg); end
  endtask

  // Offers n words back to back; fetch inputs are randomised because LOAD
  // must ignore them.
  task automatic load_words(input int n, input bit use_last, input logic [IW-1:0] base,
                            input bit rand_data, input string tag);
    logic [IW-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = rand_data ? IW'($urandom) : base * IW'(i + 1);
      bus.load_valid  = 1'b1;
      bus.load_data   = d;
      bus.load_last   = use_last && (i == n - 1);
      bus.imem_addr_F = {$urandom, $urandom};
      bus.stall_F     = 1'($urandom_range(0, 1));
      n_checks++; if (bus.load_ready !== 1'b1) begin n_fail++; $display("FAIL %s load_ready word %0d: got %b want 1", tag, i, bus.load_ready); end
      n_checks++; if ({bus.instr_valid_F, bus.fault_F, bus.instr_F} !== {2'b00, NOP}) begin
        n_fail++; $display("FAIL %s load-phase output word %0d: got v=%b f=%b i=%h want v=0 f=0 i=%h", tag, i, bus.instr_valid_F, bus.fault_F, bus.instr_F, NOP);
      end
      model_mem[exp_words] = d;
      exp_words++;
      tick();
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    bus.stall_F    = 1'b0;
  endtask

  task automatic check_entered_run(input string tag);
    n_checks++; if (state_dbg !== RUN) begin n_fail++; $display("FAIL %s state: got %0d want RUN", tag, state_dbg); end
    n_checks++; if (bus.load_ready !== 1'b0) begin n_fail++; $display("FAIL %s load_ready: got %b want 0", tag, bus.load_ready); end
    n_checks++; if (bus.words_loaded !== (AW+1)'(exp_words)) begin n_fail++; $display("FAIL %s words_loaded: got %0d want %0d", tag, bus.words_loaded, exp_words); end
    n_checks++; if (bus.instr_valid_F !== 1'b0) begin n_fail++; $display("FAIL %s first RUN instr_valid_F: got %b want 0", tag, bus.instr_valid_F); end
  endtask

  // One fetch per call; consecutive calls stream one address per cycle.
  task automatic fetch(input logic [63:0] addr, input string tag);
    logic          f;
    logic [IW:0]   e;
    f = (addr[1:0] != 2'b00) || ((addr >> (AW + 2)) != 64'd0);
    exp_q.push_back({f, f ? NOP : model_mem[addr[AW+1:2]]});
    bus.imem_addr_F = addr;
    bus.stall_F     = 1'b0;
    tick();
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      if ({bus.instr_valid_F, bus.fault_F, bus.instr_F} !== {1'b1, e}) begin
        n_fail++;
        $display("FAIL %s addr %h: got v=%b f=%b i=%h want v=1 f=%b i=%h", tag, addr, bus.instr_valid_F, bus.fault_F, bus.instr_F, e[IW], e[IW-1:0]);
      end
    end
  endtask

  task automatic test_load_four();
    load_words(4, 1'b1, 32'h11111111, 1'b0, "load4");
    check_entered_run("load4");
    fetch(64'h8, "load4_read");
    n_checks++; if (bus.instr_F !== 32'h33333333) begin n_fail++; $display("FAIL load4 literal: got %h want 33333333", bus.instr_F); end
  endtask

  task automatic test_fault();
    fetch(64'h6, "misaligned");
    fetch(64'h400, "out_of_range");
    fetch(64'h1, "misaligned_b0");
    fetch(64'h8000_0000_0000_0000, "high_bit");
    fetch(64'h4, "after_fault");
  endtask

  task automatic test_back_to_back();
    fetch(64'h0, "b2b0");
    fetch(64'h4, "b2b1");
    fetch(64'h8, "b2b2");
    fetch(64'hC, "b2b3_last_word");
  endtask

  task automatic test_stall();
    logic [IW-1:0] held;
    fetch(64'h0, "stall_pre");
    held = model_mem[0];
    for (int i = 0; i < 3; i++) begin
      bus.stall_F     = 1'b1;
      bus.imem_addr_F = (i == 0) ? 64'h0 : 64'h4;
      tick();
      n_checks++;
      if ({bus.instr_valid_F, bus.fault_F, bus.instr_F} !== {2'b10, held}) begin
        n_fail++; $display("FAIL stall cycle %0d: got v=%b f=%b i=%h want v=1 f=0 i=%h", i, bus.instr_valid_F, bus.fault_F, bus.instr_F, held);
      end
    end
    fetch(64'h4, "stall_release");
  endtask

  task automatic test_reset_midload();
    test_reset("reset_from_run");
    load_words(2, 1'b0, 32'h0BAD0BAD, 1'b0, "partial");
    n_checks++; if (bus.words_loaded !== (AW+1)'(2)) begin n_fail++; $display("FAIL partial words_loaded: got %0d want 2", bus.words_loaded); end
    n_checks++; if (state_dbg !== LOAD) begin n_fail++; $display("FAIL partial state: got %0d want LOAD", state_dbg); end
    test_reset("reset_midload");
    load_words(4, 1'b1, 32'h0A0A0A0A, 1'b0, "reload");
    check_entered_run("reload");
    fetch(64'h0, "reload0");
    fetch(64'h4, "reload1");
    fetch(64'h8, "reload2");
    fetch(64'hC, "reload3");
  endtask

  task automatic test_full_load();
    test_reset("reset_full");
    load_words(N_WORDS, 1'b0, '0, 1'b1, "full");
    check_entered_run("full");
    bus.imem_addr_F = 64'h0;
    bus.load_valid  = 1'b1;
    bus.load_data   = 32'hDEADBEEF;
    bus.load_last   = 1'b1;
    tick();
    bus.load_valid  = 1'b0;
    bus.load_last   = 1'b0;
    n_checks++; if (bus.words_loaded !== (AW+1)'(N_WORDS)) begin n_fail++; $display("FAIL extra_load words_loaded: got %0d want %0d", bus.words_loaded, N_WORDS); end
    n_checks++; if (bus.load_ready !== 1'b0) begin n_fail++; $display("FAIL extra_load load_ready: got %b want 0", bus.load_ready); end
    fetch(64'h0, "full_first");
    fetch(64'hFC, "full_top");
    for (int i = 0; i < 16; i++) fetch(64'($urandom_range(0, N_WORDS - 1)) << 2, "full_rand");
    fetch(64'h100, "full_past_top");
    fetch(64'hFE, "full_misaligned");
  endtask

  initial begin
    test_reset("reset");
    test_load_four();
    test_fault();
    test_back_to_back();
    test_stall();
    test_reset_midload();
    test_full_load();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard leftover: got %0d want 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
